// File: rtl/float8_pkg.sv
// Shared definitions for the team's 8-bit unsigned float format.
// A word is {exp, man}, its value is man * 2^exp, and there is no hidden bit.
// The adder and the subtractor both use these constants.
package float8_pkg;

  localparam int EXP_W = 3;
  localparam int MAN_W = 5;

  // Field slice positions within the 8-bit word.
  localparam int EXP_MSB = 7;
  localparam int EXP_LSB = 5;
  localparam int MAN_MSB = 4;

  localparam logic [7:0] F8_ZERO = 8'h00;
  localparam logic [7:0] F8_SAT  = 8'hFF;

endpackage

// File: rtl/float_sub_seq_if.sv
// Handshake and operand/result bundle for the sequential float subtractor.
// The requester uses the master modport and the subtractor uses the slave modport.
interface float_sub_seq_if
  import float8_pkg::*;
#(
  parameter int W = EXP_W + MAN_W
);

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         underflow;

  modport master (
    output start, a_in, b_in,
    input  busy, done, result, underflow
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, result, underflow
  );

endinterface

// File: rtl/float_sub_seq.sv
// Multi-cycle subtractor for the 8-bit unsigned float format. It computes a_in - b_in.
// Exponent alignment and normalisation each move one bit per clock.
// A negative difference clamps the result to zero and raises underflow.
module float_sub_seq
  import float8_pkg::*;
#(
  parameter int EXP_W = float8_pkg::EXP_W,
  parameter int MAN_W = float8_pkg::MAN_W
) (
  input  logic            clk,
  input  logic            reset,
  float_sub_seq_if.slave  bus
);

  localparam int W = EXP_W + MAN_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_SUB   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  // Working operands. After SUB, exp_a and man_a hold the difference
  // while it is being normalised.
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [MAN_W-1:0] man_a;
  logic [MAN_W-1:0] man_b;
  logic [W-1:0]     result_q;
  logic             underflow_q;

  // FSM and datapath. Each state performs one single-bit shift or one compare per clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the operand registers are also cleared here. This is a handful of
      // flops, not a memory, so a reset costs nothing and keeps state deterministic.
      state       <= S_IDLE;
      exp_a       <= '0;
      exp_b       <= '0;
      man_a       <= '0;
      man_b       <= '0;
      result_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignments, so each branch
      // reads the values from before the edge, which is what the hardware does.
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            exp_a <= bus.a_in[W-1:MAN_W];
            man_a <= bus.a_in[MAN_W-1:0];
            exp_b <= bus.b_in[W-1:MAN_W];
            man_b <= bus.b_in[MAN_W-1:0];
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (exp_a < exp_b) begin
            man_a <= man_a >> 1;
            exp_a <= exp_a + 1'b1;
          end else if (exp_b < exp_a) begin
            man_b <= man_b >> 1;
            exp_b <= exp_b + 1'b1;
          end else begin
            state <= S_SUB;
          end
        end
        S_SUB: begin
          if (man_a < man_b) begin
            result_q    <= '0;
            underflow_q <= 1'b1;
            state       <= S_DONE;
          end else if (man_a == man_b) begin
            result_q    <= '0;
            underflow_q <= 1'b0;
            state       <= S_DONE;
          end else begin
            man_a <= man_a - man_b;
            state <= S_NORM;
          end
        end
        S_NORM: begin
          // The exp != 0 guard keeps the exponent from wrapping below zero.
          if ((exp_a != '0) && !man_a[MAN_W-1]) begin
            man_a <= man_a << 1;
            exp_a <= exp_a - 1'b1;
          end else begin
            result_q    <= {exp_a, man_a};
            underflow_q <= 1'b0;
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status outputs are decoded directly from the state register.
  always_comb begin
    bus.busy = (state != S_IDLE);
    bus.done = (state == S_DONE);
  end

  assign bus.result    = result_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_float_sub_seq.sv
// Scoreboard bench for float_sub_seq.
// The driver pushes the hand-computed result, the underflow flag and the done cycle
// for each operation. An independent monitor pops and compares them on every done pulse.
module tb_float_sub_seq;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [7:0] res;
    logic       uf;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];

  float_sub_seq_if bus ();

  float_sub_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", {31'd0, bus.done}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", {24'd0, bus.result}, {24'd0, e.res});
          check("underflow", {31'd0, bus.underflow}, {31'd0, e.uf});
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Issues one operation and waits for its done pulse. It returns at the negedge
  // of the DONE cycle, so the next call starts in the IDLE cycle right after it.
  // When pulse is set, it also raises start with unrelated operands on cycles 2-4.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] res,
                        input logic uf, input int lat, input bit pulse);
    int t0;
    bit seen;
    @(negedge clk);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    t0 = cyc;
    sb_q.push_back('{res, uf, t0 + lat});
    @(posedge clk);
    #1 bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      @(negedge clk);
      bus.start = pulse && (i >= 2) && (i <= 4);
      if (bus.start) begin
        bus.a_in = 8'h38;
        bus.b_in = 8'h90;
      end
      if (bus.done === 1'b1) seen = 1'b1;
      else check("busy_during_op", {31'd0, bus.busy}, 32'd1);
    end
    bus.start = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = 8'h00;
    bus.b_in  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_result", {24'd0, bus.result}, 32'd0);
    check("reset_underflow", {31'd0, bus.underflow}, 32'd0);
    reset = 1'b0;

    // a, b, result, underflow, done cycle, pulse start while busy
    run_op(8'h54, 8'h48, 8'h38, 1'b0, 5, 1'b0); // equal exponents, one normalise shift
    run_op(8'h90, 8'h38, 8'h7A, 1'b0, 8, 1'b0); // three alignment shifts (back-to-back start)
    run_op(8'h7A, 8'h7A, 8'h00, 1'b0, 3, 1'b0); // exact zero, NORM skipped
    run_op(8'h38, 8'h90, 8'h00, 1'b1, 6, 1'b0); // underflow after alignment
    run_op(8'h54, 8'h48, 8'h38, 1'b0, 5, 1'b1); // start pulses while busy are ignored
    run_op(8'h23, 8'h21, 8'h04, 1'b0, 5, 1'b0); // normalisation stops at exponent 0

    // Reset during ALIGN: abort, clear the result, and never pulse done.
    @(negedge clk);
    bus.a_in  = 8'h90;
    bus.b_in  = 8'h38;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("align_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_result", {24'd0, bus.result}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_after_abort", {31'd0, bus.busy}, 32'd0);

    // Normal operation resumes after the abort.
    run_op(8'h90, 8'h38, 8'h7A, 1'b0, 8, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float_sub_seq.md
Name: float_sub_seq

Overview:
- Multi-cycle subtractor for the team's 8-bit unsigned float format: {exp[2:0], man[4:0]}, value = man * 2^exp, no hidden bit. It is the inverse operation to the combinational float adder.
- Computes a_in - b_in. Alignment and normalisation run one bit per clock under a start/busy/done handshake.
- Sits beside the adder in the lab datapath. Negative results clamp to 0x00 and raise a flag.

Parameters:
- EXP_W, 3, exponent field width.
- MAN_W, 5, mantissa field width; the word is EXP_W+MAN_W bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a_in  in  8  minuend, captured on accepted start.
- b_in  in  8  subtrahend, captured on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when result/underflow are valid.
- result  out  8  registered difference; holds until the next accepted start.
- underflow  out  1  registered; 1 when aligned a < aligned b (result forced to 0x00).

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, result=0x00, underflow=0. Internal operand registers are cleared.
- Reset mid-operation aborts to IDLE, drives no done pulse, and clears result.
- States and transitions:
  - IDLE: on start=1, capture both operands and go to ALIGN. Otherwise, start is ignored.
  - ALIGN: if the exponents differ, shift the smaller-exponent operand's mantissa right by 1 (zero fill, LSB truncated) and increment its exponent; stay in ALIGN. Exponents equal → go to SUB. Lasts d+1 cycles, d = |expA - expB| (0..7).
  - SUB: if manA < manB → result=0x00, underflow=1, go to DONE. Difference zero → result=0x00, underflow=0, go to DONE. Otherwise latch the 5-bit difference with the common exponent and go to NORM.
  - NORM: while exp != 0 and man[4] == 0, shift man left by 1 and decrement exp, one step per cycle. When either condition fails, write result={exp,man} with underflow=0 and go to DONE. Lasts k+1 cycles, k = shifts performed (0..4).
  - DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency (cycle 0 = IDLE cycle with start high):
  - Normal path: done high in cycle d+k+4.
  - Zero/underflow path: done high in cycle d+3.
  - Worst case is cycle 15.
- start while busy (including DONE) is ignored. A new start may be accepted in the IDLE cycle right after DONE.
- The SUB difference never exceeds man width, so no saturation path is needed. Exponent decrement never wraps because of the exp != 0 guard.
- All arithmetic is unsigned and truncating; no rounding.

Decomposition:
- Shared package float8_pkg holds:
  - EXP_W, MAN_W.
  - Field-slice constants (EXP_MSB=7, EXP_LSB=5, MAN_MSB=4).
  - F8_ZERO=8'h00 and F8_SAT=8'hFF, shared with the adder.
- State encoding is local to the module (5 states, binary).
- No sub-module: the single-bit shifts and the compare are inline in one FSM + datapath.

Test Plan:
- Equal exponents: a=0x54 (80), b=0x48 (32) → ALIGN 1 cycle, diff 01100, one normalise shift; result=0x38 (48), underflow=0, done at cycle 5.
- Alignment: a=0x90 (256), b=0x38 (48) → b shifted 3 times to 00011/exp4, diff 01101, normalise once; result=0x7A (208), done at cycle 8.
- Exact zero: a=b=0x7A → result=0x00, underflow=0, done at cycle 3, NORM skipped. Underflow: a=0x38, b=0x90 → result=0x00, underflow=1, done at cycle 6.
- Normalise stops at exp 0: a=0x23 (6), b=0x21 (2) → diff 00010/exp1, one shift; result=0x04, done at cycle 5.
- Handshake and reset:
  - Pulse start again on cycles 2–4 of an operation → ignored; busy stays 1 and exactly one done occurs.
  - Back-to-back: second start in the IDLE cycle after DONE is accepted.
  - Assert reset in ALIGN of a=0x90, b=0x38 → next cycle busy=0, result=0x00, and no done pulse ever appears.
